pipe_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 16-bit pipelined RISC core. It owns the write enables of the PC and the IF/ID pipeline register, the IF/ID flush, the ID/EX bubble and the next-PC select. It resolves load-use stalls, ID-stage jumps, EX-stage taken branches and instruction-memory wait states. It also keeps saturating stall and flush counters for performance debug.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 20 ++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: FSM encoding, next-PC select codes
// and the instruction field widths used by the decoder and the IF/ID register.
package pipe_hazard_ctrl_pkg;

    localparam int OPCODE_W = 4;
    localparam int REG_W    = 3;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LU_STALL   = 2'd1,
        ST_FETCH_WAIT = 2'd2,
        ST_REDIRECT   = 2'd3
    } state_t;

    localparam logic [1:0] PCSEL_SEQ = 2'd0;
    localparam logic [1:0] PCSEL_JMP = 2'd1;
    localparam logic [1:0] PCSEL_BR  = 2'd2;
    localparam logic [1:0] PCSEL_RET = 2'd3;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter: counts up on inc, sticks at all-ones, clear has priority.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] count_r;

    // Count register with saturation at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_WIDTH{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_WIDTH{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller: PC / IF/ID enables, flush, ID/EX bubble and
// next-PC select for the 16-bit pipelined core, plus stall/flush perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int OPCODE_WIDTH = OPCODE_W,
    parameter int REG_WIDTH    = REG_W,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 imem_ready,
    input  logic [REG_WIDTH-1:0] id_rs1,
    input  logic [REG_WIDTH-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic                 id_jump,
    input  logic                 id_ret,
    input  logic                 ex_is_load,
    input  logic [REG_WIDTH-1:0] ex_rd,
    input  logic                 ex_branch_taken,
    output logic                 pc_wr,
    output logic                 ifid_wr,
    output logic                 ifid_flush,
    output logic                 idex_bubble,
    output logic [1:0]           pc_sel,
    output logic                 id_valid,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    if ((OPCODE_WIDTH < 1) || (REG_WIDTH < 1) || (CNT_WIDTH < 1)) begin : g_param_check
        $error("pipe_hazard_ctrl: field and counter widths must be positive");
    end

    state_t     state_r;
    state_t     state_nxt_s;
    logic       id_valid_r;
    logic       load_use_s;
    logic       pc_wr_s;
    logic       ifid_wr_s;
    logic       ifid_flush_s;
    logic       idex_bubble_s;
    logic [1:0] pc_sel_s;

    assign load_use_s = ex_is_load & id_valid_r &
                        ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                         (id_uses_rs2 & (id_rs2 == ex_rd)));

    // Next-state and Mealy control outputs; everything forced idle while in reset
    always_comb begin
        pc_wr_s       = 1'b0;
        ifid_wr_s     = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        pc_sel_s      = PCSEL_SEQ;
        state_nxt_s   = state_r;
        if (!rst_n) begin
            state_nxt_s = ST_RUN;
        end else if (ex_branch_taken) begin
            // Both younger slots are wrong-path: kill IF/ID and ID/EX
            pc_sel_s      = PCSEL_BR;
            pc_wr_s       = 1'b1;
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
            state_nxt_s   = ST_REDIRECT;
        end else begin
            case (state_r)
                ST_FETCH_WAIT: begin
                    if (imem_ready) begin
                        pc_wr_s     = 1'b1;
                        ifid_wr_s   = 1'b1;
                        state_nxt_s = ST_RUN;
                    end else begin
                        idex_bubble_s = 1'b1;
                        state_nxt_s   = ST_FETCH_WAIT;
                    end
                end
                ST_RUN, ST_LU_STALL, ST_REDIRECT: begin
                    if (id_valid_r && (id_jump || id_ret)) begin
                        pc_sel_s     = id_jump ? PCSEL_JMP : PCSEL_RET;
                        pc_wr_s      = 1'b1;
                        ifid_flush_s = 1'b1;
                        state_nxt_s  = ST_REDIRECT;
                    end else if (load_use_s && (state_r == ST_RUN)) begin
                        // In LU_STALL the load has already moved on to MEM
                        idex_bubble_s = 1'b1;
                        state_nxt_s   = ST_LU_STALL;
                    end else if (!imem_ready) begin
                        state_nxt_s = ST_FETCH_WAIT;
                    end else begin
                        pc_wr_s     = 1'b1;
                        ifid_wr_s   = 1'b1;
                        state_nxt_s = ST_RUN;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // IF/ID valid tracking: flush wins over a simultaneous write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_r <= 1'b0;
        end else if (ifid_flush_s) begin
            id_valid_r <= 1'b0;
        end else if (ifid_wr_s && imem_ready) begin
            id_valid_r <= 1'b1;
        end else begin
            id_valid_r <= id_valid_r;
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~pc_wr_s),
        .clear (1'b0),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ifid_flush_s),
        .clear (1'b0),
        .count (flush_cnt)
    );

    assign pc_wr       = pc_wr_s;
    assign ifid_wr     = ifid_wr_s;
    assign ifid_flush  = ifid_flush_s;
    assign idex_bubble = idex_bubble_s;
    assign pc_sel      = pc_sel_s;
    assign id_valid    = id_valid_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table through a scoreboard queue,
// then hand-written reset-during-fetch-wait and counter saturation sequences.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        imem_ready;
    logic [2:0]  id_rs1;
    logic [2:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        id_jump;
    logic        id_ret;
    logic        ex_is_load;
    logic [2:0]  ex_rd;
    logic        ex_branch_taken;
    logic        pc_wr;
    logic        ifid_wr;
    logic        ifid_flush;
    logic        idex_bubble;
    logic [1:0]  pc_sel;
    logic        id_valid;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int checks = 0;
    int errors = 0;

    // expected control word layout: {pc_wr, ifid_wr, ifid_flush, idex_bubble, pc_sel}
    localparam logic [5:0] C_NORM = 6'b110000;
    localparam logic [5:0] C_LU   = 6'b000100;
    localparam logic [5:0] C_FWE  = 6'b000000;
    localparam logic [5:0] C_FWH  = 6'b000100;
    localparam logic [5:0] C_BR   = 6'b101110;
    localparam logic [5:0] C_JMP  = 6'b101001;
    localparam logic [5:0] C_RET  = 6'b101011;

    typedef struct {
        logic        rdy;
        logic        jmp;
        logic        ret;
        logic        ld;
        logic        br;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic        u1;
        logic [2:0]  rs2;
        logic        u2;
        logic [5:0]  ctl;
        logic        val;
        logic [15:0] sc;
        logic [15:0] fc;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    pipe_hazard_ctrl #(.OPCODE_WIDTH(4), .REG_WIDTH(3), .CNT_WIDTH(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_ready      (imem_ready),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .id_jump         (id_jump),
        .id_ret          (id_ret),
        .ex_is_load      (ex_is_load),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .pc_wr           (pc_wr),
        .ifid_wr         (ifid_wr),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .pc_sel          (pc_sel),
        .id_valid        (id_valid),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic rdy, input logic jmp, input logic ret,
                                 input logic ld, input logic br, input logic [2:0] rd,
                                 input logic [2:0] rs1, input logic u1,
                                 input logic [2:0] rs2, input logic u2,
                                 input logic [5:0] ctl, input logic val,
                                 input logic [15:0] sc, input logic [15:0] fc);
        vec_t v;
        v.rdy = rdy; v.jmp = jmp; v.ret = ret; v.ld = ld; v.br = br;
        v.rd = rd; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.ctl = ctl; v.val = val; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    task automatic check(input string name, input logic [5:0] ctl, input logic val,
                         input logic [15:0] sc, input logic [15:0] fc);
        logic [5:0] act;
        act = {pc_wr, ifid_wr, ifid_flush, idex_bubble, pc_sel};
        checks++;
        if (act !== ctl || id_valid !== val || stall_cnt !== sc || flush_cnt !== fc) begin
            errors++;
            $display("FAIL %s: got ctl=%b id_valid=%b stall_cnt=%0d flush_cnt=%0d, expected ctl=%b id_valid=%b stall_cnt=%0d flush_cnt=%0d",
                     name, act, id_valid, stall_cnt, flush_cnt, ctl, val, sc, fc);
        end
    endtask

    // Drive one vector at the current negedge, compare #1 later, advance to next negedge
    task automatic step(input vec_t v, input int idx);
        vec_t e;
        imem_ready = v.rdy; id_jump = v.jmp; id_ret = v.ret; ex_is_load = v.ld;
        ex_branch_taken = v.br; ex_rd = v.rd; id_rs1 = v.rs1; id_uses_rs1 = v.u1;
        id_rs2 = v.rs2; id_uses_rs2 = v.u2;
        exp_q.push_back(v);
        #1;
        e = exp_q.pop_front();
        check($sformatf("vec%0d", idx), e.ctl, e.val, e.sc, e.fc);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; imem_ready = 1'b1; id_rs1 = 3'd0; id_rs2 = 3'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_jump = 1'b0; id_ret = 1'b0;
        ex_is_load = 1'b0; ex_rd = 3'd0; ex_branch_taken = 1'b0;

        //            rdy  jmp  ret  ld   br   rd    rs1   u1   rs2   u2   ctl     val  sc  fc
        vecs.push_back(mkv(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0,C_NORM,1'b0,16'd0,16'd0));
        vecs.push_back(mkv(1'b1,1'b0,1'b0,1'b1,1'b0,3'd3,3'd1,1'b1,3'd3,1'b1,C_LU,  1'b1,16'd0,16'd0));
        vecs.push_back(mkv(1'b1,1'b0,1'b0,1'b1,1'b0,3'd3,3'd1,1'b1,3'd3,1'b1,C_NORM,1'b1,16'd1,16'd0));
        vecs.push_back(mkv(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0,C_NORM,1'b1,16'd1,16'd0));
        vecs.push_back(mkv(1'b1,1'b0,1'b0,1'b1,1'b1,3'd5,3'd5,1'b1,3'd0,1'b0,C_BR,  1'b1,16'd1,16'd0));
        vecs.push_back(mkv(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0,C_NORM,1'b0,16'd1,16'd1));
        vecs.push_back(mkv(1'b1,1'b1,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0,C_JMP, 1'b1,16'd1,16'd1));
        vecs.push_back(mkv(1'b1,1'b1,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0,C_NORM,1'b0,16'd1,16'd2));
        vecs.push_back(mkv(1'b1,1'b0,1'b1,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0,C_RET, 1'b1,16'd1,16'd2));
        vecs.push_back(mkv(1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0,C_FWE, 1'b0,16'd1,16'd3));
        vecs.push_back(mkv(1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0,C_FWH, 1'b0,16'd2,16'd3));
        vecs.push_back(mkv(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0,C_NORM,1'b0,16'd3,16'd3));
        vecs.push_back(mkv(1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0,C_FWE, 1'b1,16'd3,16'd3));
        vecs.push_back(mkv(1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0,C_FWH, 1'b1,16'd4,16'd3));
        vecs.push_back(mkv(1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0,C_FWH, 1'b1,16'd5,16'd3));
        vecs.push_back(mkv(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0,C_NORM,1'b1,16'd6,16'd3));
        vecs.push_back(mkv(1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0,C_FWE, 1'b1,16'd6,16'd3));
        vecs.push_back(mkv(1'b0,1'b0,1'b0,1'b0,1'b1,3'd0,3'd0,1'b0,3'd0,1'b0,C_BR,  1'b1,16'd7,16'd3));
        vecs.push_back(mkv(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0,C_NORM,1'b0,16'd7,16'd4));
        vecs.push_back(mkv(1'b1,1'b0,1'b0,1'b1,1'b0,3'd3,3'd3,1'b0,3'd2,1'b1,C_NORM,1'b1,16'd7,16'd4));
        vecs.push_back(mkv(1'b1,1'b1,1'b0,1'b1,1'b0,3'd2,3'd0,1'b0,3'd2,1'b1,C_JMP, 1'b1,16'd7,16'd4));
        vecs.push_back(mkv(1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b0,C_NORM,1'b0,16'd7,16'd5));

        #1;
        check("reset_state", 6'b000000, 1'b0, 16'd0, 16'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // Reset pulsed while waiting on the fetch bus, with a branch pending
        imem_ready = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        ex_branch_taken = 1'b1;
        #1;
        check("async_reset_mid_wait", 6'b000000, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ex_branch_taken = 1'b0;
        imem_ready = 1'b1;
        #1;
        check("after_reset_run", C_NORM, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        #1;
        check("after_reset_fetch", C_NORM, 1'b1, 16'd0, 16'd0);

        // Long fetch wait drives the stall counter into saturation
        imem_ready = 1'b0;
        repeat (65534) @(negedge clk);
        #1;
        check("stall_cnt_near_max", C_FWH, 1'b1, 16'hFFFE, 16'd0);
        repeat (10) @(negedge clk);
        #1;
        check("stall_cnt_saturated", C_FWH, 1'b1, 16'hFFFF, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
